// File: rtl/if_fetch_if.sv
// ============================================================================
//  Module      : if_fetch_if
//  Description : Instruction ROM bus between the fetch stage (master) and the
//                instruction memory (slave). The ROM answers combinationally
//                on the address it is given.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_fetch_if;
    logic        rom_ce_o;     // chip enable, driven by fetch
    logic [31:0] rom_addr_o;   // byte address, driven by fetch
    logic [31:0] rom_inst_i;   // instruction word, driven by ROM

    // Fetch-stage view: drives enable/address, receives the instruction.
    modport master (
        output rom_ce_o,
        output rom_addr_o,
        input  rom_inst_i
    );

    // Memory view: receives enable/address, returns the instruction.
    modport slave (
        input  rom_ce_o,
        input  rom_addr_o,
        output rom_inst_i
    );
endinterface : if_fetch_if

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
//  Module      : if_fetch
//  Description : RV32I instruction-fetch stage. Owns the program counter,
//                drives the instruction ROM and loads the IF/ID pipeline
//                register. Applies flush > stall > branch > sequential
//                next-PC priority and squashes wrong-path fetches with a
//                NOP bubble. A misaligned redirect target is delivered once
//                as a faulting IF/ID entry, after which fetch halts until
//                the next flush.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    if_fetch_if.master  rom,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_misalign_o
);

    // Fetch control states:
    //   ST_BOOT : first cycle out of reset, ROM still disabled
    //   ST_RUN  : normal fetching, ROM enabled
    //   ST_HALT : a misaligned target has been reported; wait for a flush
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] c_pc_step = 32'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_ce;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_misalign;
    logic        r_pending_misalign;

    logic        w_branch_take;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_redirect_misalign;
    logic [31:0] w_seq_pc;

    // A flush is honoured in every state; a branch only while fetching
    // and not stalled (control keeps it asserted until the stall drops).
    assign w_branch_take       = (r_state == ST_RUN) && !stall_i && branch_flag_i;
    assign w_redirect          = flush_i || w_branch_take;
    assign w_redirect_pc       = flush_i ? flush_pc_i : branch_target_i;
    assign w_redirect_misalign = (w_redirect_pc[1:0] != 2'b00);
    assign w_seq_pc            = r_pc + c_pc_step;

    // PC, fetch state and IF/ID register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= ST_BOOT;
            r_pc               <= RESET_PC;
            r_ce               <= 1'b0;
            r_id_pc            <= 32'h0000_0000;
            r_id_inst          <= NOP_INST;
            r_id_valid         <= 1'b0;
            r_id_misalign      <= 1'b0;
            r_pending_misalign <= 1'b0;
        end else if (w_redirect) begin
            // Redirect: the instruction being fetched now is wrong-path.
            r_state            <= ST_RUN;
            r_ce               <= 1'b1;
            r_pc               <= w_redirect_pc;
            r_pending_misalign <= w_redirect_misalign;
            r_id_pc            <= r_pc;
            r_id_inst          <= NOP_INST;
            r_id_valid         <= 1'b0;
            r_id_misalign      <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // ROM was disabled this cycle, so nothing to capture.
                    r_state       <= ST_RUN;
                    r_ce          <= 1'b1;
                    r_id_pc       <= r_pc;
                    r_id_inst     <= NOP_INST;
                    r_id_valid    <= 1'b0;
                    r_id_misalign <= 1'b0;
                end
                ST_RUN: begin
                    if (stall_i) begin
                        // Hold PC and IF/ID unchanged.
                        r_pc <= r_pc;
                    end else if (r_pending_misalign) begin
                        // Report the faulting target once, then stop fetching.
                        r_state            <= ST_HALT;
                        r_ce               <= 1'b0;
                        r_pending_misalign <= 1'b0;
                        r_id_pc            <= r_pc;
                        r_id_inst          <= NOP_INST;
                        r_id_valid         <= 1'b1;
                        r_id_misalign      <= 1'b1;
                    end else begin
                        r_pc          <= w_seq_pc;
                        r_id_pc       <= r_pc;
                        r_id_inst     <= rom.rom_inst_i;
                        r_id_valid    <= 1'b1;
                        r_id_misalign <= r_pending_misalign;
                    end
                end
                ST_HALT: begin
                    // Frozen PC; feed bubbles downstream unless stalled.
                    if (!stall_i) begin
                        r_id_pc       <= r_pc;
                        r_id_inst     <= NOP_INST;
                        r_id_valid    <= 1'b0;
                        r_id_misalign <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_ce    <= 1'b0;
                end
            endcase
        end
    end

    assign rom.rom_ce_o   = r_ce;
    assign rom.rom_addr_o = r_pc;
    assign id_pc_o        = r_id_pc;
    assign id_inst_o      = r_id_inst;
    assign id_valid_o     = r_id_valid;
    assign id_misalign_o  = r_id_misalign;

endmodule : if_fetch

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Self-checking bench for if_fetch. A directed prologue with
//                literal expectations is followed by randomized control
//                traffic, all compared every cycle against a behavioural
//                model of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_misalign_o;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    if_fetch_if rom_bus ();

    // ROM contents: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_bus.rom_inst_i = rom_bus.rom_ce_o ? rom_word(rom_bus.rom_addr_o) : 32'h0;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom             (rom_bus),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_misalign_o   (id_misalign_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_ce, m_id_valid, m_id_mis;
    bit          m_booting, m_halted, m_pend;

    task automatic m_bubble();
        m_id_pc    = m_pc;
        m_id_inst  = NOP_INST;
        m_id_valid = 1'b0;
        m_id_mis   = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RESET_PC; m_ce = 1'b0;
            m_booting = 1; m_halted = 0; m_pend = 0;
            m_id_pc = 32'h0; m_id_inst = NOP_INST; m_id_valid = 1'b0; m_id_mis = 1'b0;
        end else if (flush_i) begin
            m_bubble();
            m_pc = flush_pc_i; m_pend = (flush_pc_i % 4) != 0;
            m_ce = 1'b1; m_booting = 0; m_halted = 0;
        end else if (m_booting) begin
            m_bubble();
            m_ce = 1'b1; m_booting = 0;
        end else if (stall_i) begin
            // everything holds
        end else if (m_halted) begin
            m_bubble();
        end else if (branch_flag_i) begin
            m_bubble();
            m_pc = branch_target_i; m_pend = (branch_target_i % 4) != 0;
        end else if (m_pend) begin
            m_id_pc = m_pc; m_id_inst = NOP_INST; m_id_valid = 1'b1; m_id_mis = 1'b1;
            m_ce = 1'b0; m_halted = 1; m_pend = 0;
        end else begin
            m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_valid = 1'b1; m_id_mis = 1'b0;
            m_pc = m_pc + 32'd4;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks++;
            if ({rom_bus.rom_ce_o, rom_bus.rom_addr_o, id_pc_o, id_inst_o, id_valid_o, id_misalign_o} !==
                {m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid, m_id_mis}) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t: got ce=%0b addr=%h id_pc=%h inst=%h v=%0b mis=%0b, want ce=%0b addr=%h id_pc=%h inst=%h v=%0b mis=%0b",
                         $time, rom_bus.rom_ce_o, rom_bus.rom_addr_o, id_pc_o, id_inst_o, id_valid_o, id_misalign_o,
                         m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid, m_id_mis);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0, 1:    t = $urandom_range(0, 255);
            2:       t = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            default: t = $urandom;
        endcase
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit prev_rst;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
        branch_flag_i = 1'b0; branch_target_i = 32'h0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset_pc", rom_bus.rom_addr_o, 32'h0);
        chk("reset_ce", 32'(rom_bus.rom_ce_o), 32'h0);
        chk("reset_inst", id_inst_o, NOP_INST);
        chk("reset_valid", 32'(id_valid_o), 32'h0);

        rst = 1'b0;
        tick();
        chk("boot_ce", 32'(rom_bus.rom_ce_o), 32'h1);
        chk("boot_valid", 32'(id_valid_o), 32'h0);
        tick();
        chk("seq0_pc", id_pc_o, 32'h0);
        chk("seq0_inst", id_inst_o, 32'h1000_0000);
        tick();
        chk("seq1_inst", id_inst_o, 32'h1000_0001);
        chk("seq1_addr", rom_bus.rom_addr_o, 32'h8);

        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr", rom_bus.rom_addr_o, 32'h8);
            chk("stall_id_pc", id_pc_o, 32'h4);
        end
        stall_i = 1'b0;
        tick();
        chk("resume_id_pc", id_pc_o, 32'h8);
        chk("resume_inst", id_inst_o, 32'h1000_0002);
        tick();
        chk("pre_br_addr", rom_bus.rom_addr_o, 32'h10);

        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        tick();
        branch_flag_i = 1'b0;
        chk("br_bubble_inst", id_inst_o, NOP_INST);
        chk("br_bubble_valid", 32'(id_valid_o), 32'h0);
        chk("br_addr", rom_bus.rom_addr_o, 32'h40);
        tick();
        chk("br_target_id_pc", id_pc_o, 32'h40);
        chk("br_target_inst", id_inst_o, 32'h1000_0010);

        flush_i = 1'b1; stall_i = 1'b1; flush_pc_i = 32'h100;
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        chk("flush_addr", rom_bus.rom_addr_o, 32'h100);
        chk("flush_valid", 32'(id_valid_o), 32'h0);
        tick();
        chk("flush_inst", id_inst_o, 32'h1000_0040);

        branch_flag_i = 1'b1; branch_target_i = 32'h42;
        tick();
        branch_flag_i = 1'b0;
        chk("mis_addr", rom_bus.rom_addr_o, 32'h42);
        tick();
        chk("mis_id_pc", id_pc_o, 32'h42);
        chk("mis_flag", 32'(id_misalign_o), 32'h1);
        chk("mis_valid", 32'(id_valid_o), 32'h1);
        chk("mis_ce", 32'(rom_bus.rom_ce_o), 32'h0);
        tick();
        tick();
        chk("halt_ce", 32'(rom_bus.rom_ce_o), 32'h0);
        chk("halt_valid", 32'(id_valid_o), 32'h0);
        chk("halt_addr", rom_bus.rom_addr_o, 32'h42);

        flush_i = 1'b1; flush_pc_i = 32'h80;
        tick();
        flush_i = 1'b0;
        chk("restart_ce", 32'(rom_bus.rom_ce_o), 32'h1);
        tick();
        chk("restart_id_pc", id_pc_o, 32'h80);
        chk("restart_inst", id_inst_o, 32'h1000_0020);

        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
        tick();
        flush_i = 1'b0;
        tick();
        chk("wrap_inst", id_inst_o, 32'h4FFF_FFFF);
        chk("wrap_addr", rom_bus.rom_addr_o, 32'h0);

        rst = 1'b1; stall_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h200;
        tick();
        chk("midrst_addr", rom_bus.rom_addr_o, RESET_PC);
        chk("midrst_ce", 32'(rom_bus.rom_ce_o), 32'h0);
        chk("midrst_id_pc", id_pc_o, 32'h0);
        chk("midrst_valid", 32'(id_valid_o), 32'h0);
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

        // Randomized control traffic; the boot cycle after reset is kept quiet.
        prev_rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = !prev_rst && ($urandom_range(0, 199) == 0);
            if (prev_rst) begin
                stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
            end else begin
                stall_i       = ($urandom_range(0, 99) < 20);
                flush_i       = ($urandom_range(0, 99) < 8);
                branch_flag_i = ($urandom_range(0, 99) < 25);
            end
            flush_pc_i      = rand_target();
            branch_target_i = rand_target();
            prev_rst = rst;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_if_fetch

`default_nettype wire
